// File: rtl/wave_gen_pkg.sv
// Shared FSM states, wave_sel codes and width defaults for the DAC waveform sequencer.
package wave_gen_pkg;

  localparam int ADDR_W_DEFAULT = 12;
  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  typedef enum logic [1:0] {
    WAVE_ROM0 = 2'b00,
    WAVE_ROM1 = 2'b01,
    WAVE_ZERO = 2'b10,
    WAVE_ROM2 = 2'b11
  } wave_sel_e;

endpackage

// File: rtl/dac_wave_sequencer_if.sv
// DAC write bus: active-low chip-select and write strobe, channel select and data.
interface dac_wave_sequencer_if #(
  parameter int DATA_W = wave_gen_pkg::DATA_W_DEFAULT
) ();

  logic              DAC_CS;
  logic              DAC_WR;
  logic              DACAB;
  logic [DATA_W-1:0] DAC_DATA;

  modport master (output DAC_CS, DAC_WR, DACAB, DAC_DATA);
  modport slave  (input  DAC_CS, DAC_WR, DACAB, DAC_DATA);

endinterface

// File: rtl/dac_amp_scaler.sv
// Combinational amplitude scaler: scaled = data * (amp + 1) / 16, so amp = 15 is unity gain.
module dac_amp_scaler
  import wave_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [3:0]        amp_i,
  output logic [DATA_W-1:0] scaled_o
);

  logic [4:0]        gain;
  logic [DATA_W+3:0] product;

  assign gain = {1'b0, amp_i} + 5'd1;

  // Largest product is (2^DATA_W - 1) * 16, so DATA_W + 4 bits cannot overflow.
  assign product  = (DATA_W+4)'(data_i) * (DATA_W+4)'(gain);
  assign scaled_o = DATA_W'(product >> 4);

endmodule

// File: rtl/dac_wave_sequencer.sv
// Fetches ROM samples, scales them by amp and writes them to the DAC with SETUP/STROBE/HOLD.
// Define DAC_DUAL_CH_EN to follow each channel-A write with an inverted channel-B write.
module dac_wave_sequencer
  import wave_gen_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int ROM_LAT = 1
) (
  input  logic                 clk_5M,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           wave_sel,
  input  logic [3:0]           freq_step,
  input  logic [3:0]           amp,
  input  logic [DATA_W-1:0]    rom_data0,
  input  logic [DATA_W-1:0]    rom_data1,
  input  logic [DATA_W-1:0]    rom_data2,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic                 busy,
  output logic                 sample_tick,
  dac_wave_sequencer_if.master dac
);

  localparam logic [1:0] LAST_WAIT = 2'(ROM_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] romAddr_q, romAddr_d;
  logic [1:0]        waitCnt_q, waitCnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        step_q, step_d;
  logic [3:0]        amp_q, amp_d;
  logic [DATA_W-1:0] dacData_q, dacData_d;
  logic [DATA_W-1:0] selData;
  logic [DATA_W-1:0] scaledData;
  logic              lastHold;
  logic              dacCs;
  logic              dacWr;

`ifdef DAC_DUAL_CH_EN
  logic chanB_q, chanB_d;
  logic dacAb_q, dacAb_d;

  assign lastHold = chanB_q;
`else
  assign lastHold = 1'b1;
`endif

  always_ff @(posedge clk_5M) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      romAddr_q <= '0;
      waitCnt_q <= '0;
      sel_q     <= '0;
      step_q    <= '0;
      amp_q     <= '0;
      dacData_q <= '0;
`ifdef DAC_DUAL_CH_EN
      chanB_q   <= 1'b0;
      dacAb_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      romAddr_q <= romAddr_d;
      waitCnt_q <= waitCnt_d;
      sel_q     <= sel_d;
      step_q    <= step_d;
      amp_q     <= amp_d;
      dacData_q <= dacData_d;
`ifdef DAC_DUAL_CH_EN
      chanB_q   <= chanB_d;
      dacAb_q   <= dacAb_d;
`endif
    end
  end

  always_comb begin
    selData = '0;
    case (sel_q)
      WAVE_ROM0: selData = rom_data0;
      WAVE_ROM1: selData = rom_data1;
      WAVE_ROM2: selData = rom_data2;
      default:   selData = '0;
    endcase
  end

  dac_amp_scaler #(
    .DATA_W (DATA_W)
  ) uScaler (
    .data_i   (selData),
    .amp_i    (amp_q),
    .scaled_o (scaledData)
  );

  // Sample controls are captured once in FETCH so mid-sample input changes wait for the next sample.
  always_comb begin
    state_d   = state_q;
    romAddr_d = romAddr_q;
    waitCnt_d = waitCnt_q;
    sel_d     = sel_q;
    step_d    = step_q;
    amp_d     = amp_q;
    dacData_d = dacData_q;
`ifdef DAC_DUAL_CH_EN
    chanB_d   = chanB_q;
    dacAb_d   = dacAb_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable) state_d = FETCH;
      end
      FETCH: begin
        sel_d     = wave_sel;
        step_d    = freq_step;
        amp_d     = amp;
        waitCnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (waitCnt_q == LAST_WAIT) begin
          dacData_d = scaledData;
          state_d   = SETUP;
`ifdef DAC_DUAL_CH_EN
          chanB_d   = 1'b0;
          dacAb_d   = 1'b0;
`endif
        end else begin
          waitCnt_d = waitCnt_q + 2'd1;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: state_d = HOLD;
      HOLD: begin
        if (lastHold) begin
          romAddr_d = romAddr_q + ADDR_W'(step_q);
          state_d   = enable ? FETCH : IDLE;
        end
`ifdef DAC_DUAL_CH_EN
        else begin
          chanB_d   = 1'b1;
          dacAb_d   = 1'b1;
          dacData_d = ~dacData_q;
          state_d   = SETUP;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dacCs       = 1'b1;
    dacWr       = 1'b1;
    busy        = 1'b1;
    sample_tick = 1'b0;
    case (state_q)
      IDLE:   busy = 1'b0;
      SETUP:  dacCs = 1'b0;
      STROBE: begin
        dacCs = 1'b0;
        dacWr = 1'b0;
      end
      HOLD: begin
        dacCs       = 1'b0;
        sample_tick = lastHold;
      end
      default: ;
    endcase
  end

  assign rom_addr     = romAddr_q;
  assign dac.DAC_CS   = dacCs;
  assign dac.DAC_WR   = dacWr;
  assign dac.DAC_DATA = dacData_q;
`ifdef DAC_DUAL_CH_EN
  assign dac.DACAB    = dacAb_q;
`else
  assign dac.DACAB    = 1'b0;
`endif

endmodule

// File: tb/tb_dac_wave_sequencer.sv
// Randomized self-checking bench for dac_wave_sequencer against a sample-phase reference model.
// Define DAC_DUAL_CH_EN to exercise the dual-channel variant.
module tb_dac_wave_sequencer;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int ROM_LAT = 1;
  localparam int ADDR_SPACE = 1 << ADDR_W;
  localparam int DATA_MAX   = (1 << DATA_W) - 1;
`ifdef DAC_DUAL_CH_EN
  localparam bit DUAL   = 1'b1;
  localparam int PERIOD = ROM_LAT + 7;
  localparam int SPS    = 2;
`else
  localparam bit DUAL   = 1'b0;
  localparam int PERIOD = ROM_LAT + 4;
  localparam int SPS    = 1;
`endif

  logic              clk_5M = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [1:0]        wave_sel = 2'b00;
  logic [3:0]        freq_step = 4'd0;
  logic [3:0]        amp = 4'd0;
  logic [DATA_W-1:0] rom_data0, rom_data1, rom_data2;
  logic [ADDR_W-1:0] rom_addr;
  logic              busy, sample_tick;

  dac_wave_sequencer_if #(.DATA_W(DATA_W)) dacBus ();

  dac_wave_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ROM_LAT(ROM_LAT)
  ) dut (
    .clk_5M     (clk_5M),
    .rst_n      (rst_n),
    .enable     (enable),
    .wave_sel   (wave_sel),
    .freq_step  (freq_step),
    .amp        (amp),
    .rom_data0  (rom_data0),
    .rom_data1  (rom_data1),
    .rom_data2  (rom_data2),
    .rom_addr   (rom_addr),
    .busy       (busy),
    .sample_tick(sample_tick),
    .dac        (dacBus)
  );

  always #100 clk_5M = ~clk_5M;

  // ROM: rom_dataN = addr[7:0] + N*64, presented ROM_LAT cycles after the address.
  logic [ADDR_W-1:0] romPipe [ROM_LAT];
  always @(posedge clk_5M) begin
    romPipe[0] <= rom_addr;
    for (int i = 1; i < ROM_LAT; i++) romPipe[i] <= romPipe[i-1];
  end
  assign rom_data0 = romPipe[ROM_LAT-1][7:0];
  assign rom_data1 = romPipe[ROM_LAT-1][7:0] + 8'd64;
  assign rom_data2 = romPipe[ROM_LAT-1][7:0] + 8'd128;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobeData[$];
  int strobeAb[$];
  int strobeCyc[$];

  // Reference model: a sample is PERIOD cycles, phase 0 = fetch, strobe at ROM_LAT+2 (and +5 for B).
  bit mActive = 1'b0;
  int mPhase = 0, mAddr = 0, mData = 0, mAb = 0;
  int mSel = 0, mStep = 0, mAmp = 0;

  function automatic int scaleRef(input int sel, input int addr, input int ampCode);
    int romVal;
    if (sel == 2) return 0;
    romVal = (addr % 256 + (sel == 1 ? 64 : (sel == 3 ? 128 : 0))) % 256;
    return romVal * (ampCode + 1) / 16;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(posedge clk_5M) begin
    cyc++;
    if (!rst_n) begin
      mActive = 1'b0;
      mPhase  = 0;
      mAddr   = 0;
      mData   = 0;
      mAb     = 0;
    end else if (!mActive) begin
      if (enable) begin
        mActive = 1'b1;
        mPhase  = 0;
      end
    end else begin
      if (mPhase == 0) begin
        mSel  = int'(wave_sel);
        mStep = int'(freq_step);
        mAmp  = int'(amp);
      end
      if (mPhase == ROM_LAT) begin
        mData = scaleRef(mSel, mAddr, mAmp);
        mAb   = 0;
      end
      if (DUAL && mPhase == ROM_LAT + 3) begin
        mData = DATA_MAX - mData;
        mAb   = 1;
      end
      if (mPhase == PERIOD - 1) begin
        mAddr = (mAddr + mStep) % ADDR_SPACE;
        if (enable) mPhase = 0;
        else mActive = 1'b0;
      end else begin
        mPhase++;
      end
    end
  end

  always @(posedge clk_5M) begin
    #1;
    checkOutput("cs", 32'(dacBus.DAC_CS), 32'(!(mActive && mPhase >= ROM_LAT + 1)));
    checkOutput("wr", 32'(dacBus.DAC_WR),
                32'(!(mActive && (mPhase == ROM_LAT + 2 || (DUAL && mPhase == ROM_LAT + 5)))));
    checkOutput("busy", 32'(busy), 32'(mActive));
    checkOutput("tick", 32'(sample_tick), 32'(mActive && mPhase == PERIOD - 1));
    checkOutput("addr", 32'(rom_addr), mAddr);
    checkOutput("data", 32'(dacBus.DAC_DATA), mData);
    checkOutput("dacab", 32'(dacBus.DACAB), mAb);
    if (dacBus.DAC_WR === 1'b0) begin
      strobeData.push_back(int'(dacBus.DAC_DATA));
      strobeAb.push_back(int'(dacBus.DACAB));
      strobeCyc.push_back(cyc);
    end
  end

  task automatic applyStimulus(input bit en, input logic [1:0] sel, input logic [3:0] stepV,
                               input logic [3:0] ampV);
    enable    = en;
    wave_sel  = sel;
    freq_step = stepV;
    amp       = ampV;
  endtask

  task automatic clearStrobes();
    strobeData.delete();
    strobeAb.delete();
    strobeCyc.delete();
  endtask

  task automatic waitStrobes(input int n, input int budget);
    int k = 0;
    while (strobeData.size() < n && k < budget) begin
      @(negedge clk_5M);
      k++;
    end
    checkOutput("strobe_count", 32'(strobeData.size() >= n), 1);
  endtask

  task automatic waitTick(input int budget);
    int k = 0;
    while (sample_tick !== 1'b1 && k < budget) begin
      @(negedge clk_5M);
      k++;
    end
    checkOutput("tick_seen", 32'(sample_tick), 1);
  endtask

  task automatic waitCsLow(input int budget);
    int k = 0;
    while (dacBus.DAC_CS !== 1'b0 && k < budget) begin
      @(negedge clk_5M);
      k++;
    end
    checkOutput("cs_low_seen", 32'(dacBus.DAC_CS), 0);
  endtask

  initial begin
    int k;

    repeat (3) @(negedge clk_5M);
    checkOutput("reset_cs", 32'(dacBus.DAC_CS), 1);
    checkOutput("reset_wr", 32'(dacBus.DAC_WR), 1);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_addr", 32'(rom_addr), 0);
    checkOutput("reset_data", 32'(dacBus.DAC_DATA), 0);

    // Unity gain ramp from address 0.
`ifdef DAC_DUAL_CH_EN
    applyStimulus(1'b1, 2'b00, 4'd15, 4'd15);
    rst_n = 1'b1;
    clearStrobes();
    waitStrobes(11, 120);
    checkOutput("dual_a_data", strobeData[8], 32'h3C);
    checkOutput("dual_a_ab", strobeAb[8], 0);
    checkOutput("dual_b_data", strobeData[9], 32'hC3);
    checkOutput("dual_b_ab", strobeAb[9], 1);
    checkOutput("dual_period", strobeCyc[10] - strobeCyc[8], 8);
`else
    applyStimulus(1'b1, 2'b00, 4'd1, 4'd15);
    rst_n = 1'b1;
    clearStrobes();
    waitStrobes(3, 40);
    checkOutput("ramp_data0", strobeData[0], 0);
    checkOutput("ramp_data1", strobeData[1], 1);
    checkOutput("ramp_data2", strobeData[2], 2);
    checkOutput("ramp_period1", strobeCyc[1] - strobeCyc[0], 5);
    checkOutput("ramp_period2", strobeCyc[2] - strobeCyc[1], 5);
`endif

    // wave 1 at half-ish gain, reaching address 136 after 17 samples.
    @(negedge clk_5M);
    rst_n = 1'b0;
    @(negedge clk_5M);
    applyStimulus(1'b1, 2'b01, 4'd8, 4'd7);
    rst_n = 1'b1;
    clearStrobes();
    waitStrobes(17 * SPS + 1, 20 * PERIOD);
    checkOutput("sel1_addr136", strobeData[17 * SPS], 100);

    // Zero waveform keeps strobing with zero data.
    wave_sel = 2'b10;
    waitTick(2 * PERIOD);
    clearStrobes();
    waitStrobes(SPS, 2 * PERIOD);
    checkOutput("zero_wave", strobeData[0], 0);
`ifdef DAC_DUAL_CH_EN
    checkOutput("zero_wave_b", strobeData[1], DATA_MAX);
`endif

    // amp changed in SETUP only affects the following sample; step 0 holds address 0.
    @(negedge clk_5M);
    rst_n = 1'b0;
    @(negedge clk_5M);
    applyStimulus(1'b1, 2'b01, 4'd0, 4'd15);
    rst_n = 1'b1;
    clearStrobes();
    waitCsLow(4 * PERIOD);
    amp = 4'd0;
    waitStrobes(SPS + 1, 4 * PERIOD);
    checkOutput("amp_old_scale", strobeData[0], 64);
    checkOutput("amp_new_scale", strobeData[SPS], 4);

    // enable dropped in SETUP: sample completes with its address advance, then IDLE.
    freq_step = 4'd5;
    waitTick(2 * PERIOD);
    @(negedge clk_5M);
    waitCsLow(2 * PERIOD);
    enable = 1'b0;
    repeat (3 * SPS - 1) @(negedge clk_5M);
    checkOutput("drop_final_hold_busy", 32'(busy), 1);
    checkOutput("drop_final_hold_tick", 32'(sample_tick), 1);
    @(negedge clk_5M);
    checkOutput("drop_idle_cs", 32'(dacBus.DAC_CS), 1);
    checkOutput("drop_idle_wr", 32'(dacBus.DAC_WR), 1);
    checkOutput("drop_idle_busy", 32'(busy), 0);
    checkOutput("drop_idle_addr", 32'(rom_addr), 5);

    // Reset asserted mid-STROBE.
    enable = 1'b1;
    k = 0;
    while (dacBus.DAC_WR !== 1'b0 && k < 2 * PERIOD) begin
      @(negedge clk_5M);
      k++;
    end
    checkOutput("strobe_seen", 32'(dacBus.DAC_WR), 0);
    rst_n = 1'b0;
    @(posedge clk_5M);
    #1;
    checkOutput("rst_strobe_wr", 32'(dacBus.DAC_WR), 1);
    checkOutput("rst_strobe_cs", 32'(dacBus.DAC_CS), 1);
    checkOutput("rst_strobe_addr", 32'(rom_addr), 0);

    // Address wrap: 4094 + 3 -> 1.
    @(negedge clk_5M);
    applyStimulus(1'b1, 2'b00, 4'd2, 4'd15);
    rst_n = 1'b1;
    k = 0;
    while (rom_addr !== 12'd4094 && k < 2100 * PERIOD) begin
      @(negedge clk_5M);
      k++;
    end
    checkOutput("wrap_reach", 32'(rom_addr), 4094);
    freq_step = 4'd3;
    k = 0;
    while (rom_addr === 12'd4094 && k < 2 * PERIOD) begin
      @(negedge clk_5M);
      k++;
    end
    checkOutput("wrap_addr", 32'(rom_addr), 1);

    // Random traffic with occasional resets; the model checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_5M);
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 2) == 0)
        applyStimulus($urandom_range(0, 7) != 0, 2'($urandom), 4'($urandom), 4'($urandom));
    end

    repeat (2) @(negedge clk_5M);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
